// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared CDB packet type, FU count and grant-index type
package cdb_arbiter_pkg;

  localparam int CDB_N_FU  = 4;
  localparam int CDB_PTR_W = $clog2(CDB_N_FU);
  localparam int ROB_IDX_W = 6;

  // Result packet carried from a functional unit onto the common data bus
  typedef struct packed {
    logic [ROB_IDX_W-1:0] dest_ROB_entry;
    logic [31:0]          result;
    logic                 branch_result;
    logic                 from_memory;
  } CDB_packet_t;

  typedef logic [CDB_PTR_W-1:0] cdb_grant_idx_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - FU valid/yumi request bundle plus CDB broadcast bus
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int N_FU = CDB_N_FU
);

  logic [N_FU-1:0]              fu_valid;
  CDB_packet_t [N_FU-1:0]       fu_packet;
  logic [N_FU-1:0]              fu_yumi;
  logic                         cdb_valid;
  CDB_packet_t                  cdb_packet;

  // Arbiter side: consumes FU results, drives acknowledges and the bus
  modport master (
    input  fu_valid,
    input  fu_packet,
    output fu_yumi,
    output cdb_valid,
    output cdb_packet
  );

  // FU / listener side
  modport slave (
    output fu_valid,
    output fu_packet,
    input  fu_yumi,
    input  cdb_valid,
    input  cdb_packet
  );

endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// rtl/cdb_arbiter_rr_pick.sv - combinational rotate-priority encoder starting at ptr
module cdb_arbiter_rr_pick #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] win,
  output logic         any
);

  // Walk offsets from farthest to nearest so the request closest to ptr is the last writer
  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    win   = '0;
    any   = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        win = W'(idx);
        any = 1'b1;
      end
    end
    if (any) grant[win] = 1'b1;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin CDB arbiter, one-cycle broadcast; CDB_MEM_PRIORITY_EN adds memory-packet priority
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter  int N_FU  = CDB_N_FU,
  localparam int PTR_W = $clog2(N_FU)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  cdb_arbiter_if.master     bus
);

  logic [PTR_W-1:0] rr_ptr;
  logic [N_FU-1:0]  rr_grant;
  logic [PTR_W-1:0] rr_win;
  logic             rr_any;

  logic [N_FU-1:0]  sel_grant;
  logic [PTR_W-1:0] sel_win;
  logic             sel_any;
  logic             mem_win;
  logic             grant_ok;

  cdb_arbiter_rr_pick #(.N(N_FU)) u_rr_pick (
    .req   (bus.fu_valid),
    .ptr   (rr_ptr),
    .grant (rr_grant),
    .win   (rr_win),
    .any   (rr_any)
  );

`ifdef CDB_MEM_PRIORITY_EN
  logic             mem_any;
  logic [PTR_W-1:0] mem_idx;

  // Lowest-index valid memory packet preempts the round-robin choice
  always_comb begin
    mem_any = 1'b0;
    mem_idx = '0;
    for (int i = N_FU - 1; i >= 0; i--) begin
      if (bus.fu_valid[i] && bus.fu_packet[i].from_memory) begin
        mem_any = 1'b1;
        mem_idx = PTR_W'(i);
      end
    end
  end

  assign sel_grant = mem_any ? (N_FU'(1) << mem_idx) : rr_grant;
  assign sel_win   = mem_any ? mem_idx : rr_win;
  assign sel_any   = mem_any | rr_any;
  assign mem_win   = mem_any;
`else
  assign sel_grant = rr_grant;
  assign sel_win   = rr_win;
  assign sel_any   = rr_any;
  assign mem_win   = 1'b0;
`endif

  // Reset and flush both suppress the acknowledge in the same cycle
  assign grant_ok    = sel_any & ~reset & ~flush;
  assign bus.fu_yumi = grant_ok ? sel_grant : '0;

  // Register the winner onto the bus for one cycle and advance the pointer past it
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.cdb_valid  <= 1'b0;
      bus.cdb_packet <= '0;
      rr_ptr         <= '0;
    end else begin
      bus.cdb_valid <= grant_ok;
      if (grant_ok) begin
        bus.cdb_packet <= bus.fu_packet[sel_win];
        if (!mem_win) begin
          rr_ptr <= (sel_win == PTR_W'(N_FU - 1)) ? '0 : sel_win + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed plus randomized check of cdb_arbiter against a behavioural model
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.N_FU(N)) bus ();

  cdb_arbiter #(.N_FU(N)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // stimulus state: FU requests and control
  logic [N-1:0] v;
  CDB_packet_t  p [N];
  bit           r;
  bit           f;

  // reference model state
  int           m_ptr;
  bit           exp_cv;
  CDB_packet_t  exp_pkt;
  logic [N-1:0] exp_yumi;
  int           win;
  bit           mem;
  logic [N-1:0] obs_yumi;

  task automatic check(string tag, logic [63:0] got, logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Pick the winner from the arbitration rules: memory priority (if built in), else first valid from the pointer
  task automatic predict();
    win = -1;
    mem = 1'b0;
    exp_yumi = '0;
    if (!r && !f) begin
`ifdef CDB_MEM_PRIORITY_EN
      for (int i = 0; i < N; i++) begin
        if (win < 0 && v[i] && p[i].from_memory) begin
          win = i;
          mem = 1'b1;
        end
      end
`endif
      for (int k = 0; k < N; k++) begin
        if (win < 0 && v[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      end
      if (win >= 0) exp_yumi[win] = 1'b1;
    end
  endtask

  // One clock: drive at negedge, check grant before posedge, check bus at next negedge
  task automatic cycle(string tag);
    reset = r;
    flush = f;
    bus.fu_valid = v;
    for (int i = 0; i < N; i++) bus.fu_packet[i] = p[i];
    #1;
    predict();
    obs_yumi = bus.fu_yumi;
    check({tag, ":yumi"}, 64'(obs_yumi), 64'(exp_yumi));
    @(posedge clk);
    if (r) begin
      m_ptr   = 0;
      exp_cv  = 1'b0;
      exp_pkt = '0;
    end else begin
      exp_cv = (win >= 0);
      if (win >= 0) begin
        exp_pkt = p[win];
        if (!mem) m_ptr = (win + 1) % N;
      end
    end
    @(negedge clk);
    check({tag, ":cdb_valid"}, 64'(bus.cdb_valid), 64'(exp_cv));
    if (exp_cv || r) check({tag, ":cdb_packet"}, 64'(bus.cdb_packet), 64'(exp_pkt));
  endtask

  // Granted FUs drop their request for the next cycle
  task automatic retire();
    v = v & ~exp_yumi;
  endtask

  function automatic CDB_packet_t rand_pkt(bit allow_mem);
    CDB_packet_t q;
    q.dest_ROB_entry = ROB_IDX_W'($urandom);
    q.result         = $urandom;
    q.branch_result  = 1'($urandom);
    q.from_memory    = allow_mem && ($urandom_range(0, 3) == 0);
    return q;
  endfunction

  initial begin
    r = 1'b1;
    f = 1'b0;
    v = '0;
    m_ptr = 0;
    exp_cv = 1'b0;
    exp_pkt = '0;
    for (int i = 0; i < N; i++) p[i] = '0;
    reset = 1'b1;
    flush = 1'b0;
    bus.fu_valid = '0;
    for (int i = 0; i < N; i++) bus.fu_packet[i] = '0;
    @(negedge clk);

    // reset state
    cycle("reset");
    r = 1'b0;

    // single request from FU2
    p[2] = '{dest_ROB_entry: 6'd5, result: 32'h0000_00FF, branch_result: 1'b0, from_memory: 1'b0};
    v = 4'b0100;
    cycle("single");
    check("single:onehot", 64'(obs_yumi), 64'h4);
    check("single:rob", 64'(bus.cdb_packet.dest_ROB_entry), 64'd5);
    check("single:result", 64'(bus.cdb_packet.result), 64'hFF);
    retire();
    cycle("single_idle");
    check("single_idle:valid", 64'(bus.cdb_valid), 64'd0);

    // round-robin fairness with all FUs requesting
    r = 1'b1;
    cycle("rr_reset");
    r = 1'b0;
    for (int i = 0; i < N; i++) p[i] = rand_pkt(1'b0);
    v = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      cycle("rr");
      check("rr:order", 64'(obs_yumi), 64'(1) << (k % N));
      check("rr:continuous", 64'(bus.cdb_valid), 64'd1);
      v = 4'b1111 & ~exp_yumi;
      p[k % N] = rand_pkt(1'b0);
    end

    // pointer wrap with sparse requests
    v = 4'b0100;
    cycle("wrap_setup");
    v = 4'b0011;
    cycle("wrap_a");
    check("wrap:fu0", 64'(obs_yumi), 64'h1);
    retire();
    cycle("wrap_b");
    check("wrap:fu1", 64'(obs_yumi), 64'h2);
    retire();

    // flush suppresses grant and broadcast, pointer holds
    v = 4'b0010;
    f = 1'b1;
    cycle("flush");
    check("flush:no_yumi", 64'(obs_yumi), 64'h0);
    f = 1'b0;
    cycle("flush_after");
    check("flush_after:fu1", 64'(obs_yumi), 64'h2);
    v = 4'b1111 & ~exp_yumi;
    f = 1'b1;
    cycle("flush_all");
    f = 1'b0;
    v = 4'b1111;
    cycle("flush_ptr_held");
    check("flush_ptr_held:fu2", 64'(obs_yumi), 64'h4);
    retire();
    v = '0;
    cycle("flush_drain");

    // reset during a broadcast
    v = 4'b0010;
    cycle("rst_mid_grant");
    check("rst_mid_grant:bcast", 64'(bus.cdb_valid), 64'd1);
    retire();
    v = 4'b1101;
    r = 1'b1;
    cycle("rst_mid");
    check("rst_mid:no_yumi", 64'(obs_yumi), 64'h0);
    check("rst_mid:dropped", 64'(bus.cdb_valid), 64'd0);
    r = 1'b0;
    v = 4'b1010;
    cycle("rst_after");
    check("rst_after:ptr0", 64'(obs_yumi), 64'h2);
    retire();
    v = '0;
    cycle("rst_drain");

    // memory-priority scenario
    r = 1'b1;
    cycle("mem_reset");
    r = 1'b0;
    p[0] = rand_pkt(1'b0);
    p[3] = rand_pkt(1'b0);
    p[3].from_memory = 1'b1;
    v = 4'b1001;
    cycle("mem");
`ifdef CDB_MEM_PRIORITY_EN
    check("mem:fu3", 64'(obs_yumi), 64'h8);
`else
    check("mem:fu0", 64'(obs_yumi), 64'h1);
`endif
    for (int i = 0; i < N; i++) p[i].from_memory = 1'b0;
    v = 4'b1111 & ~exp_yumi;
    cycle("mem_next");
`ifdef CDB_MEM_PRIORITY_EN
    check("mem_next:ptr_held", 64'(obs_yumi), 64'h1);
`else
    check("mem_next:ptr_moved", 64'(obs_yumi), 64'h2);
`endif
    retire();

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      r = ($urandom_range(0, 49) == 0);
      f = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < N; i++) begin
        if (!v[i] && $urandom_range(0, 2) != 0) begin
          v[i] = 1'b1;
          p[i] = rand_pkt(1'b1);
        end
      end
      cycle("rnd");
      retire();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
